// File: rtl/ssd_pkg.sv
// Shared types, defaults and digit helpers for the seven-segment scan controller.
package ssd_pkg;

    localparam int NUM_DIGITS          = 4;
    localparam int DIGIT_W             = 4;
    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_CNT_W       = 17;

    typedef logic [1:0]  digit_sel_t;
    typedef logic [15:0] disp_word_t;

    function automatic logic [DIGIT_W-1:0] nibble_of(input disp_word_t word, input digit_sel_t idx);
        logic [DIGIT_W-1:0] nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
    function automatic logic lead_zero_blank(input disp_word_t word, input digit_sel_t idx);
        logic blank;
        case (idx)
            2'd3:    blank = (word[15:12] == 4'h0);
            2'd2:    blank = (word[15:8]  == 8'h00);
            2'd1:    blank = (word[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/ssd_refresh_prescaler.sv
// Refresh divider: counts 0..DIV-1 while enabled and flags the last count as a tick.
module ssd_refresh_prescaler #(
    parameter int DIV   = 100000,
    parameter int CNT_W = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    assign tick = en & (count_r == LAST);

    // Next count: clear wins, wrap after the last count, hold when disabled.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (tick) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (en) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous double buffering.
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  num,
    output logic [1:0]  sel,
    output logic        digit_blank,
    output logic        pending,
    output logic        frame_done
);

    logic               tick_s;
    logic               boundary_s;

    disp_word_t         staging_r;
    disp_word_t         display_r;
    digit_sel_t         sel_r;
    logic [DIGIT_W-1:0] num_r;
    logic               blank_r;
    logic               pending_r;
    logic               frame_done_r;

    disp_word_t         staging_next_s;
    disp_word_t         display_next_s;
    digit_sel_t         sel_next_s;
    logic [DIGIT_W-1:0] num_next_s;
    logic               blank_next_s;
    logic               pending_next_s;

    ssd_refresh_prescaler #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (~en),
        .tick  (tick_s)
    );

    assign boundary_s = tick_s & (sel_r == 2'd3);

    // Buffer update: a boundary promotes staging (or a same-cycle load directly), otherwise load stages.
    always_comb begin
        staging_next_s = staging_r;
        display_next_s = display_r;
        pending_next_s = pending_r;
        if (boundary_s) begin
            if (load) begin
                staging_next_s = value;
                display_next_s = value;
                pending_next_s = 1'b0;
            end else if (pending_r) begin
                display_next_s = staging_r;
                pending_next_s = 1'b0;
            end else begin
                pending_next_s = 1'b0;
            end
        end else if (load) begin
            staging_next_s = value;
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Digit sequencing: num is looked up from the post-transfer word so sel=0 shows new data.
    always_comb begin
        sel_next_s = sel_r;
        num_next_s = num_r;
        if (tick_s) begin
            sel_next_s = sel_r + 2'd1;
            num_next_s = nibble_of(display_next_s, sel_r + 2'd1);
        end else begin
            sel_next_s = sel_r;
            num_next_s = num_r;
        end
    end

    // Blanking decision, registered alongside num and sel.
    always_comb begin
        blank_next_s = 1'b1;
        if (!en) begin
            blank_next_s = 1'b1;
        end else begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
            blank_next_s = lead_zero_blank(display_next_s, sel_next_s);
`else
            blank_next_s = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_r    <= 16'h0000;
            display_r    <= 16'h0000;
            sel_r        <= 2'd0;
            num_r        <= 4'h0;
            blank_r      <= 1'b1;
            pending_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            staging_r    <= staging_next_s;
            display_r    <= display_next_s;
            sel_r        <= sel_next_s;
            num_r        <= num_next_s;
            blank_r      <= blank_next_s;
            pending_r    <= pending_next_s;
            frame_done_r <= boundary_s;
        end
    end

    assign num         = num_r;
    assign sel         = sel_r;
    assign digit_blank = blank_r;
    assign pending     = pending_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a 4-cycle refresh slot.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  num;
    logic [1:0]  sel;
    logic        digit_blank;
    logic        pending;
    logic        frame_done;

    int n_checks;
    int n_errors;

    ssd_scan_ctrl #(
        .REFRESH_DIV (4),
        .CNT_W       (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .value       (value),
        .num         (num),
        .sel         (sel),
        .digit_blank (digit_blank),
        .pending     (pending),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected blank for a lit, enabled display.
    function automatic logic exp_blank(input logic [15:0] word, input logic [1:0] s);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        logic [15:0] upper;
        if (s == 2'd0) return 1'b0;
        upper = word >> (4 * s);
        return (upper == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_digit(input string tag, input logic [1:0] s, input logic [3:0] n, input logic [15:0] word);
        chk({tag, "_sel"}, {30'd0, sel}, {30'd0, s});
        chk({tag, "_num"}, {28'd0, num}, {28'd0, n});
        chk({tag, "_blank"}, {31'd0, digit_blank}, {31'd0, exp_blank(word, s)});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_num", {28'd0, num}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_blank", {31'd0, digit_blank}, 32'd1);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);

        // Enable with display 0000: sel steps every 4 cycles.
        en = 1'b1;
        cyc(1);
        chk_digit("en0", 2'd0, 4'h0, 16'h0000);
        cyc(3);
        chk_digit("s1", 2'd1, 4'h0, 16'h0000);
        cyc(4);
        chk_digit("s2", 2'd2, 4'h0, 16'h0000);
        cyc(4);
        chk_digit("s3", 2'd3, 4'h0, 16'h0000);
        cyc(4);
        chk_digit("s0", 2'd0, 4'h0, 16'h0000);
        chk("fd_first", {31'd0, frame_done}, 32'd1);
        cyc(4);
        chk("sel1_again", {30'd0, sel}, 32'd1);

        // Load 1A3F during sel=1: pending until the frame boundary.
        load = 1'b1; value = 16'h1A3F;
        cyc(1);
        load = 1'b0; value = 16'h0000;
        chk("ld_pending", {31'd0, pending}, 32'd1);
        chk("ld_num_hold", {28'd0, num}, 32'd0);
        cyc(3);
        chk_digit("ld_s2", 2'd2, 4'h0, 16'h0000);
        cyc(4);
        chk_digit("ld_s3", 2'd3, 4'h0, 16'h0000);
        chk("ld_pend_s3", {31'd0, pending}, 32'd1);
        cyc(4);
        chk_digit("bd_s0", 2'd0, 4'hF, 16'h1A3F);
        chk("bd_fd", {31'd0, frame_done}, 32'd1);
        chk("bd_pending", {31'd0, pending}, 32'd0);
        cyc(1);
        chk("bd_fd_once", {31'd0, frame_done}, 32'd0);
        cyc(3);
        chk_digit("nx_s1", 2'd1, 4'h3, 16'h1A3F);
        cyc(4);
        chk_digit("nx_s2", 2'd2, 4'hA, 16'h1A3F);
        cyc(4);
        chk_digit("nx_s3", 2'd3, 4'h1, 16'h1A3F);

        // Load on the boundary tick cycle goes straight to display.
        cyc(3);
        load = 1'b1; value = 16'h0042;
        cyc(1);
        load = 1'b0; value = 16'h0000;
        chk_digit("direct_s0", 2'd0, 4'h2, 16'h0042);
        chk("direct_pending", {31'd0, pending}, 32'd0);
        chk("direct_fd", {31'd0, frame_done}, 32'd1);
        cyc(4);
        chk_digit("d42_s1", 2'd1, 4'h4, 16'h0042);
        cyc(4);
        chk_digit("d42_s2", 2'd2, 4'h0, 16'h0042);
        cyc(4);
        chk_digit("d42_s3", 2'd3, 4'h0, 16'h0042);

        // Back-to-back loads: last wins.
        load = 1'b1; value = 16'h1111;
        cyc(1);
        value = 16'h2222;
        cyc(1);
        load = 1'b0; value = 16'h0000;
        chk("b2b_pending", {31'd0, pending}, 32'd1);
        cyc(2);
        chk_digit("b2b_s0", 2'd0, 4'h2, 16'h2222);
        cyc(4);
        chk_digit("b2b_s1", 2'd1, 4'h2, 16'h2222);
        cyc(4);
        chk_digit("b2b_s2", 2'd2, 4'h2, 16'h2222);
        cyc(4);
        chk_digit("b2b_s3", 2'd3, 4'h2, 16'h2222);

        // Disable mid-slot; a load while disabled still stages.
        cyc(2);
        en = 1'b0;
        cyc(1);
        chk("dis_blank", {31'd0, digit_blank}, 32'd1);
        chk("dis_sel", {30'd0, sel}, 32'd3);
        load = 1'b1; value = 16'h5678;
        cyc(1);
        load = 1'b0; value = 16'h0000;
        chk("dis_ld_pending", {31'd0, pending}, 32'd1);
        cyc(6);
        chk("dis_sel_frozen", {30'd0, sel}, 32'd3);
        chk("dis_no_fd", {31'd0, frame_done}, 32'd0);
        chk("dis_num", {28'd0, num}, 32'd2);

        // Re-enable: the held sel=3 slot lasts a full 4 cycles.
        en = 1'b1;
        cyc(1);
        chk_digit("ren_r1", 2'd3, 4'h2, 16'h2222);
        cyc(2);
        chk("ren_r3_sel", {30'd0, sel}, 32'd3);
        cyc(1);
        chk_digit("ren_r4", 2'd0, 4'h8, 16'h5678);
        chk("ren_fd", {31'd0, frame_done}, 32'd1);
        chk("ren_pending", {31'd0, pending}, 32'd0);

        // Asynchronous reset mid-frame with a staged value.
        cyc(5);
        load = 1'b1; value = 16'h9999;
        cyc(1);
        load = 1'b0; value = 16'h0000;
        chk("pre_rst_pending", {31'd0, pending}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_num", {28'd0, num}, 32'd0);
        chk("arst_sel", {30'd0, sel}, 32'd0);
        chk("arst_blank", {31'd0, digit_blank}, 32'd1);
        chk("arst_pending", {31'd0, pending}, 32'd0);
        chk("arst_fd", {31'd0, frame_done}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk_digit("post_s0", 2'd0, 4'h0, 16'h0000);
        cyc(3);
        chk_digit("post_s1", 2'd1, 4'h0, 16'h0000);
        cyc(8);
        chk_digit("post_s3", 2'd3, 4'h0, 16'h0000);
        cyc(4);
        chk_digit("post_s0b", 2'd0, 4'h0, 16'h0000);
        chk("post_pending", {31'd0, pending}, 32'd0);
        chk("post_fd", {31'd0, frame_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Overall time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
